// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that configures, runs and services an interval timer slave:
// programs period/mode, acknowledges timeouts, stops on request and reads 32-bit snapshots.
`timescale 1ns/1ps

module timer_ctrl_master #(
  parameter int TICK_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           period_value,
  input  logic                  continuous,
  input  logic                  stop_req,
  input  logic                  snap_req,
  input  logic                  irq,
  output logic [2:0]            address,
  output logic                  chipselect,
  output logic                  write_n,
  output logic [15:0]           writedata,
  input  logic [15:0]           readdata,
  output logic                  busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_WIDTH-1:0] tick_count,
  output logic [31:0]           snapshot_value,
  output logic                  snapshot_valid
);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERIODL = 3'd2;
  localparam logic [2:0] A_PERIODH = 3'd3;
  localparam logic [2:0] A_SNAPL   = 3'd4;
  localparam logic [2:0] A_SNAPH   = 3'd5;

  localparam logic [15:0] CTRL_STOP      = 16'h0008;
  localparam logic [15:0] CTRL_START_ITO = 16'h0005;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_STOP,
    S_CFG_PL,
    S_CFG_PH,
    S_CFG_CTRL,
    S_RUN,
    S_ACK,
    S_HALT,
    S_SNAP_WR,
    S_SNAP_RDL,
    S_SNAP_RDH,
    S_SNAP_CAP
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pend;
  logic        snap_pend;

  // Next state and the single-cycle bus access issued by the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    state_d    = state;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;

    case (state)
      S_IDLE: begin
        if (start) state_d = S_CFG_STOP;
      end
      S_CFG_STOP: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_CONTROL;
        writedata  = CTRL_STOP;
        state_d    = S_CFG_PL;
      end
      S_CFG_PL: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_PERIODL;
        writedata  = period_q[15:0];
        state_d    = S_CFG_PH;
      end
      S_CFG_PH: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_PERIODH;
        writedata  = period_q[31:16];
        state_d    = S_CFG_CTRL;
      end
      S_CFG_CTRL: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_CONTROL;
        writedata  = CTRL_START_ITO | {14'd0, cont_q, 1'b0};
        state_d    = S_RUN;
      end
      S_RUN: begin
        // irq is a level, so one raised during any service state is picked up here.
        if (irq)            state_d = S_ACK;
        else if (stop_pend) state_d = S_HALT;
        else if (snap_pend) state_d = S_SNAP_WR;
      end
      S_ACK: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_STATUS;
        state_d    = cont_q ? S_RUN : S_IDLE;
      end
      S_HALT: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_CONTROL;
        writedata  = CTRL_STOP;
        state_d    = S_IDLE;
      end
      S_SNAP_WR: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = A_SNAPL;
        state_d    = S_SNAP_RDL;
      end
      S_SNAP_RDL: begin
        chipselect = 1'b1;
        address    = A_SNAPL;
        state_d    = S_SNAP_RDH;
      end
      S_SNAP_RDH: begin
        chipselect = 1'b1;
        address    = A_SNAPH;
        state_d    = S_SNAP_CAP;
      end
      S_SNAP_CAP: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign running = state inside {S_RUN, S_ACK, S_HALT, S_SNAP_WR, S_SNAP_RDL, S_SNAP_RDH, S_SNAP_CAP};

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      cont_q   <= 1'b0;
    end else if (state == S_IDLE && start) begin
      period_q <= period_value;
      cont_q   <= continuous;
    end
  end

  // Requests are remembered outside IDLE; a fresh request wins over a same-cycle service clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stop_pend <= 1'b0;
      snap_pend <= 1'b0;
    end else if (state_d == S_IDLE) begin
      stop_pend <= 1'b0;
      snap_pend <= 1'b0;
    end else begin
      if (stop_req && state != S_IDLE) stop_pend <= 1'b1;
      else if (state == S_HALT)        stop_pend <= 1'b0;

      if (snap_req && state != S_IDLE) snap_pend <= 1'b1;
      else if (state == S_SNAP_CAP)    snap_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= (state == S_ACK);
      if (state == S_IDLE && start) tick_count <= '0;
      else if (state == S_ACK)      tick_count <= tick_count + TICK_WIDTH'(1);
    end
  end

  // Read data for an access appears one cycle later, so each half is captured a state after its read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot_value <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      snapshot_valid <= (state == S_SNAP_CAP);
      if (state == S_SNAP_RDH) snapshot_value[15:0]  <= readdata;
      if (state == S_SNAP_CAP) snapshot_value[31:16] <= readdata;
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master: a timer slave model answers the bus, a transaction-level
// model queues the expected bus accesses, ticks and snapshots, and a monitor pops and compares them.
`timescale 1ns/1ps

module tb_timer_ctrl_master;

  typedef enum int {EV_WR, EV_RD, EV_TICK, EV_SNAP} ev_t;

  typedef struct {
    ev_t         kind;
    logic [2:0]  addr;
    logic [63:0] data;
    longint      at;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] period_value = '0;
  logic        continuous = 1'b0;
  logic        stop_req = 1'b0;
  logic        snap_req = 1'b0;
  logic        irq;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata = '0;
  logic        busy;
  logic        running;
  logic        tick;
  logic [31:0] tick_count;
  logic [31:0] snapshot_value;
  logic        snapshot_valid;

  logic        irq_src = 1'b0;
  logic        irq_kill = 1'b0;
  logic        irq_q = 1'b0;
  logic [31:0] snap_src = '0;
  logic [31:0] snap_lat = '0;

  longint cyc = 0;
  int     errors = 0;
  int     checks = 0;
  exp_t   q[$];
  longint m_ticks = 0;
  bit     m_cont = 1'b0;
  bit     m_running = 1'b0;

  timer_ctrl_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .period_value   (period_value),
    .continuous     (continuous),
    .stop_req       (stop_req),
    .snap_req       (snap_req),
    .irq            (irq),
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .busy           (busy),
    .running        (running),
    .tick           (tick),
    .tick_count     (tick_count),
    .snapshot_value (snapshot_value),
    .snapshot_valid (snapshot_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: TO level held until status write, snapshot latched on a4 write, read latency 1.
  assign irq = irq_src | irq_q;
  always @(posedge clk) begin
    irq_q <= (irq_src | irq_q) & ~(chipselect & ~write_n & (address == 3'd0)) & ~irq_kill;
    if (chipselect && !write_n && address == 3'd4) snap_lat <= snap_src;
    if (chipselect && write_n)
      readdata <= (address == 3'd4) ? snap_lat[15:0] : (address == 3'd5) ? snap_lat[31:16] : 16'hDEAD;
    else
      readdata <= 16'($urandom);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input ev_t k, input logic [2:0] a, input logic [63:0] d, input longint at);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic observe(input ev_t k, input logic [2:0] a, input logic [63:0] d);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind=%s addr=%0d data=%0h at cycle %0d, expected no event",
               k.name(), a, d, cyc);
    end else begin
      e = q.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      if (k == e.kind) begin
        if (k == EV_WR || k == EV_RD) check("event_addr", 64'(a), 64'(e.addr));
        if (k != EV_RD) check("event_data", d, e.data);
        if (e.at >= 0) check("event_cycle", 64'(cyc), 64'(e.at));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (chipselect) observe(write_n ? EV_RD : EV_WR, address, {48'd0, writedata});
      else check("bus_idle", {44'd0, write_n, address, writedata}, {44'd0, 1'b1, 3'd0, 16'd0});
      if (tick) observe(EV_TICK, 3'd0, 64'(tick_count));
      if (snapshot_valid) observe(EV_SNAP, 3'd0, 64'(snapshot_value));
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    step();
    step();
  endtask

  // Snapshot sequence: write a4, read a4, read a5 back to back, value valid two cycles after the last read.
  task automatic push_snap(input longint w, input logic [31:0] v);
    push(EV_WR, 3'd4, 64'd0, w);
    push(EV_RD, 3'd4, 64'd0, w + 1);
    push(EV_RD, 3'd5, 64'd0, w + 2);
    push(EV_SNAP, 3'd0, 64'(v), w + 4);
  endtask

  task automatic do_start(input logic [31:0] p, input logic c);
    longint t = cyc;
    start        = 1'b1;
    period_value = p;
    continuous   = c;
    push(EV_WR, 3'd1, 64'h0008, t + 1);
    push(EV_WR, 3'd2, 64'(p[15:0]), t + 2);
    push(EV_WR, 3'd3, 64'(p[31:16]), t + 3);
    push(EV_WR, 3'd1, c ? 64'h0007 : 64'h0005, t + 4);
    m_ticks   = 0;
    m_cont    = c;
    m_running = 1'b1;
    step();
    start        = 1'b0;
    period_value = $urandom;
    continuous   = 1'($urandom);
  endtask

  // Timeout acknowledged first; a same-cycle snap request survives only in continuous mode.
  task automatic do_irq(input bit with_snap);
    longint t = cyc;
    irq_src  = 1'b1;
    snap_req = with_snap;
    push(EV_WR, 3'd0, 64'd0, t + 1);
    m_ticks++;
    push(EV_TICK, 3'd0, 64'(m_ticks % (64'd1 << 32)), t + 2);
    if (with_snap && m_cont) push_snap(t + 3, snap_src);
    if (!m_cont) m_running = 1'b0;
    step();
    irq_src  = 1'b0;
    snap_req = 1'b0;
    drain();
  endtask

  task automatic do_snap();
    longint t = cyc;
    snap_req = 1'b1;
    push_snap(t + 2, snap_src);
    step();
    snap_req = 1'b0;
    drain();
  endtask

  task automatic do_stop(input bit with_snap);
    longint t = cyc;
    stop_req = 1'b1;
    snap_req = with_snap;
    push(EV_WR, 3'd1, 64'h0008, t + 2);
    m_running = 1'b0;
    step();
    stop_req = 1'b0;
    snap_req = 1'b0;
    drain();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_address"}, 64'(address), 64'd0);
    check({tag, "_chipselect"}, 64'(chipselect), 64'd0);
    check({tag, "_write_n"}, 64'(write_n), 64'd1);
    check({tag, "_writedata"}, 64'(writedata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_running"}, 64'(running), 64'd0);
    check({tag, "_tick"}, 64'(tick), 64'd0);
    check({tag, "_tick_count"}, 64'(tick_count), 64'd0);
    check({tag, "_snapshot_value"}, 64'(snapshot_value), 64'd0);
    check({tag, "_snapshot_valid"}, 64'(snapshot_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t;

    step();
    step();
    check_reset("reset");
    reset_n = 1'b1;
    step();

    // Continuous configuration, three timeouts, snapshot, snapshot racing an irq, stop.
    do_start(32'h0001_2345, 1'b1);
    drain();
    check("run_busy", 64'(busy), 64'd1);
    check("run_running", 64'(running), 64'd1);
    do_irq(1'b0);
    check("tick_count_1", 64'(tick_count), 64'd1);
    do_irq(1'b0);
    do_irq(1'b0);
    check("tick_count_3", 64'(tick_count), 64'd3);
    snap_src = 32'h0012_BEEF;
    do_snap();
    check("snapshot_beef", 64'(snapshot_value), 64'h0012_BEEF);
    snap_src = $urandom;
    do_irq(1'b1);
    check("tick_count_4", 64'(tick_count), 64'd4);
    do_stop(1'b0);
    check("stopped_busy", 64'(busy), 64'd0);
    check("stopped_running", 64'(running), 64'd0);

    // One-shot: a single ACK returns to IDLE, a later irq is ignored.
    do_start($urandom, 1'b0);
    drain();
    do_irq(1'b0);
    check("oneshot_busy", 64'(busy), 64'd0);
    check("oneshot_running", 64'(running), 64'd0);
    check("oneshot_tick_count", 64'(tick_count), 64'd1);
    irq_src = 1'b1;
    step();
    irq_src = 1'b0;
    repeat (10) step();
    check("oneshot_irq_ignored", 64'(busy), 64'd0);
    irq_kill = 1'b1;
    step();
    irq_kill = 1'b0;

    // Stop requested while the period high word is being written.
    t = cyc;
    do_start($urandom, 1'b1);
    step();
    step();
    stop_req = 1'b1;
    push(EV_WR, 3'd1, 64'h0008, t + 6);
    m_running = 1'b0;
    step();
    stop_req = 1'b0;
    drain();
    check("cfg_stop_busy", 64'(busy), 64'd0);

    for (int it = 0; it < 12; it++) begin
      stop_req = 1'($urandom);
      snap_req = 1'($urandom);
      step();
      stop_req = 1'b0;
      snap_req = 1'b0;
      do_start($urandom, 1'($urandom));
      drain();
      for (int op = 0; op < 4 && m_running; op++) begin
        repeat ($urandom_range(0, 3)) step();
        case ($urandom_range(0, 3))
          0: do_irq(1'b0);
          1: begin
            snap_src = $urandom;
            do_snap();
          end
          2: begin
            snap_src = $urandom;
            do_irq(1'b1);
          end
          default: begin
            start        = 1'b1;
            period_value = $urandom;
            continuous   = 1'($urandom);
            step();
            start = 1'b0;
            drain();
          end
        endcase
      end
      if (m_running) do_stop(1'($urandom));
    end

    // Reset asserted in the middle of the low snapshot read.
    do_start($urandom, 1'b1);
    drain();
    do_irq(1'b0);
    snap_src = 32'hCAFE_F00D;
    t = cyc;
    snap_req = 1'b1;
    push_snap(t + 2, snap_src);
    step();
    snap_req = 1'b0;
    step();
    step();
    check("pre_reset_rdl", {61'd0, chipselect, write_n, address == 3'd4}, {61'd0, 3'b111});
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("midreset");
    q.delete();
    m_running = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    check("post_reset_busy", 64'(busy), 64'd0);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_master.md
Name: timer_ctrl_master

Overview:
- Avalon-MM master sequencer that programs and services the 16-bit-data interval timer slave (s1, 3-bit word address) in hardware, so no Nios II software is needed to run it.
- Configures period and mode, starts the timer, and acknowledges each timeout IRQ by writing the status register.
- Counts ticks and, on request, takes and reads back a 32-bit counter snapshot.
- Sits beside the timer on the system interconnect, with its master port wired directly to the timer slave.

Parameters:
TICK_WIDTH, 32, width of tick_count; wraps modulo 2^TICK_WIDTH.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; load period_value/continuous and begin configuration (honoured only in IDLE)
period_value  in  32  timer period, sampled with start
continuous  in  1  1 = periodic, 0 = one-shot; sampled with start
stop_req  in  1  1-cycle pulse; stop a running timer
snap_req  in  1  1-cycle pulse; capture and read the counter snapshot
irq  in  1  timer irq (level)
address  out  3  master word address to timer
chipselect  out  1  master chipselect
write_n  out  1  master write strobe, active low
writedata  out  16  master write data
readdata  in  16  timer read data; fixed read latency 1, no waitrequest
busy  out  1  high in every state except IDLE
running  out  1  high in RUN and in all service states
tick  out  1  1-cycle pulse per acknowledged timeout
tick_count  out  TICK_WIDTH  acknowledged timeouts since the last start
snapshot_value  out  32  last snapshot read back
snapshot_valid  out  1  1-cycle pulse when snapshot_value updates

Behaviour:
- Reset values (async, reset_n low): state IDLE; chipselect 0; write_n 1; address 0; writedata 0; busy 0; running 0; tick 0; tick_count 0; snapshot_value 0; snapshot_valid 0; pending flags 0.
- Bus rule: every bus access lasts exactly one cycle, with chipselect=1. Writes use write_n=0; reads use write_n=1. Outside an access: chipselect=0, write_n=1, address and writedata hold 0.
- Read data for an access in cycle N is sampled at the end of cycle N+1.
- State machine, one state per cycle unless stated:
  - IDLE: on start, latch period_value and continuous, clear tick_count, go to CFG_STOP. Otherwise stay.
  - CFG_STOP: write addr1 = 0x0008 (stop).
  - CFG_PL: write addr2 = period[15:0].
  - CFG_PH: write addr3 = period[31:16].
  - CFG_CTRL: write addr1 = 0x0005 | (continuous<<1) (START, ITO, CONT). Then go to RUN.
  - RUN: no bus access. Priority is irq, then pending stop, then pending snap:
    - irq: go to ACK.
    - pending stop: go to HALT.
    - pending snap: go to SNAP_WR.
  - ACK: write addr0 = 0x0000 (clear TO). Next cycle: tick=1 and tick_count+1. Then:
    - continuous: back to RUN.
    - one-shot: to IDLE, clearing the pending flags.
  - HALT: write addr1 = 0x0008, clear pending stop, go to IDLE.
  - SNAP_WR: write addr4 = 0x0000.
  - SNAP_RDL: read addr4.
  - SNAP_RDH: read addr5; capture readdata into snapshot_value[15:0].
  - SNAP_CAP: capture readdata into snapshot_value[31:16], pulse snapshot_valid, clear pending snap, return to RUN.
- Pending flags: a stop_req or snap_req pulse sets a flag in any state except IDLE. In IDLE the pulse is ignored. Flags are cleared only when serviced or on entry to IDLE.
- start outside IDLE is ignored.
- irq that arrives during a service or configuration state is not lost, because irq is a level. It is taken on the next RUN cycle.
- irq sampled in IDLE or a CFG state has no effect until RUN.
- Simultaneous stop_req and snap_req: both flags set; stop wins and clears both on entry to IDLE.
- tick_count wraps from all-ones to 0 with no flag.
- Reset mid-operation: immediately returns to the reset values. The timer slave is not written, and it retains its state.

Test Plan:
- Start with period_value=0x0001_2345 and continuous=1. Required: bus writes in order {a1,0x0008}, {a2,0x2345}, {a3,0x0001}, {a1,0x0007}, on consecutive cycles; busy=1, running=1.
- In RUN, assert irq. Required: ACK write {a0,0x0000} the next cycle, then tick pulse and tick_count=1. Repeat irq twice more → tick_count=3.
- One-shot (continuous=0) with irq. Required: control write 0x0005; after ACK the state is IDLE with busy=0 and tick_count=1; a second irq produces no bus activity.
- snap_req in RUN with the timer returning 0xBEEF@a4 and 0x0012@a5. Required: {a4 write}, read a4, read a5 on consecutive cycles; snapshot_value=0x0012_BEEF with a one-cycle snapshot_valid.
- snap_req and irq in the same cycle. Required: ACK serviced first, then the snapshot sequence; tick_count increments exactly once.
- stop_req during CFG_PH. Required: configuration completes, one RUN cycle, then {a1,0x0008}, then IDLE. Additionally: reset_n low mid-SNAP_RDL → all outputs at reset values in the same cycle.
